// File: rtl/proc_w.sv
// proc_w: parametrised multicycle bus processor.
// Executes mv, mvi, add, sub, and, mvnz (move if Z=0) and nop over a
// W-bit shared bus. Each instruction is fetched in T0. Register-to-register
// moves retire in T1, and ALU ops retire in T3. All architectural state is
// cleared asynchronously by Resetn.

module proc_w #(
  parameter int W = 9
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [W-1:0] DIN,
  input  logic         Run,
  output logic         Done,
  output logic [W-1:0] BusWires
);

  // Step counter encoding
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  // Bus source selector; SEL_NONE drives the bus to zero
  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_RY   = 3'd1,
    SEL_RX   = 3'd2,
    SEL_G    = 3'd3,
    SEL_DIN  = 3'd4
  } bus_sel_t;

  // Opcodes held in IR[8:6]
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;

  // ALU result for the ALU opcodes. No carry or overflow leaves this function.
  function automatic logic [W-1:0] alu_f(
    input logic [2:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] res;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      default: res = {W{1'b0}};
    endcase
    return res;
  endfunction

  // Architectural state
  step_t        r_step;
  logic [8:0]   r_ir;
  logic [W-1:0] r_regs [0:7];
  logic [W-1:0] r_a;
  logic [W-1:0] r_g;
  logic         r_z;

  // Decode and control
  step_t        w_step_next;
  bus_sel_t     w_sel;
  logic         w_ir_wr;
  logic         w_reg_wr;
  logic         w_a_wr;
  logic         w_g_wr;
  logic         w_done;
  logic [2:0]   w_op;
  logic [2:0]   w_x;
  logic [2:0]   w_y;
  logic [W-1:0] w_alu;
  logic         w_alu_zero;

  assign w_op = r_ir[8:6];
  assign w_x  = r_ir[5:3];
  assign w_y  = r_ir[2:0];

  // Step register. Reset returns to T0 immediately.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_step <= T0;
    end else begin
      r_step <= w_step_next;
    end
  end

  // Next-step logic and per-step control strobes
  always_comb begin
    w_step_next = r_step;
    w_sel       = SEL_NONE;
    w_ir_wr     = 1'b0;
    w_reg_wr    = 1'b0;
    w_a_wr      = 1'b0;
    w_g_wr      = 1'b0;
    w_done      = 1'b0;
    case (r_step)
      T0: begin
        if (Run) begin
          w_ir_wr     = 1'b1;
          w_step_next = T1;
        end else begin
          w_step_next = T0;
        end
      end
      T1: begin
        case (w_op)
          OP_MV: begin
            w_sel       = SEL_RY;
            w_reg_wr    = 1'b1;
            w_done      = 1'b1;
            w_step_next = T0;
          end
          OP_MVI: begin
            w_sel       = SEL_DIN;
            w_reg_wr    = 1'b1;
            w_done      = 1'b1;
            w_step_next = T0;
          end
          OP_MVNZ: begin
            // With Z=1 the bus stays idle and nothing is written.
            if (!r_z) begin
              w_sel    = SEL_RY;
              w_reg_wr = 1'b1;
            end else begin
              w_sel    = SEL_NONE;
              w_reg_wr = 1'b0;
            end
            w_done      = 1'b1;
            w_step_next = T0;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            w_sel       = SEL_RX;
            w_a_wr      = 1'b1;
            w_step_next = T2;
          end
          default: begin
            // 110 and 111 are no-ops that still retire in one step.
            w_done      = 1'b1;
            w_step_next = T0;
          end
        endcase
      end
      T2: begin
        w_sel       = SEL_RY;
        w_g_wr      = 1'b1;
        w_step_next = T3;
      end
      T3: begin
        w_sel       = SEL_G;
        w_reg_wr    = 1'b1;
        w_done      = 1'b1;
        w_step_next = T0;
      end
      default: begin
        w_step_next = T0;
      end
    endcase
  end

  // Shared bus multiplexer. Only one source is selected at a time.
  always_comb begin
    BusWires = {W{1'b0}};
    case (w_sel)
      SEL_RY:  BusWires = r_regs[w_y];
      SEL_RX:  BusWires = r_regs[w_x];
      SEL_G:   BusWires = r_g;
      SEL_DIN: BusWires = DIN;
      default: BusWires = {W{1'b0}};
    endcase
  end

  assign w_alu      = alu_f(w_op, r_a, BusWires);
  assign w_alu_zero = (w_alu == {W{1'b0}});
  assign Done       = w_done;

  // Instruction register. It loads only on a Run-qualified fetch in T0.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_ir <= 9'd0;
    end else if (w_ir_wr) begin
      r_ir <= DIN[8:0];
    end
  end

  // Accumulator: captures the first ALU operand in T1
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_a <= {W{1'b0}};
    end else if (w_a_wr) begin
      r_a <= BusWires;
    end
  end

  // Result register and zero flag. Both update only on the T2 edge of an ALU op.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_g <= {W{1'b0}};
      r_z <= 1'b1;
    end else if (w_g_wr) begin
      r_g <= w_alu;
      r_z <= w_alu_zero;
    end
  end

  // General-purpose register file. It is written from the bus on retiring steps.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= {W{1'b0}};
      end
    end else if (w_reg_wr) begin
      r_regs[w_x] <= BusWires;
    end
  end

endmodule

// File: tb/tb_proc_w.sv
// Testbench for proc_w. It runs a W=9 and a W=16 instance in lockstep on the
// same instruction stream. A per-instruction reference model predicts the bus
// value and Done for every step.

module tb_proc_w;

  logic        clk;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        done9;
  logic        done16;
  logic [8:0]  bus9;
  logic [15:0] bus16;

  int n_assert;
  int n_fail;

  // Reference state: index 0 models W=9, index 1 models W=16
  logic [15:0] m_r [2][8];
  logic        m_z [2];
  logic [15:0] m_mask [2];

  proc_w #(.W(9)) u9 (
    .Clock    (clk),
    .Resetn   (resetn),
    .DIN      (din[8:0]),
    .Run      (run),
    .Done     (done9),
    .BusWires (bus9)
  );

  proc_w #(.W(16)) u16 (
    .Clock    (clk),
    .Resetn   (resetn),
    .DIN      (din),
    .Run      (run),
    .Done     (done16),
    .BusWires (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] mask);
    logic [15:0] r;
    case (op)
      3'b010:  r = a + b;
      3'b011:  r = a - b;
      default: r = a & b;
    endcase
    return r & mask;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_r[k][i] = 16'h0000;
      m_z[k] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_step(input string tag, input logic [15:0] eb9, input logic [15:0] eb16,
                            input logic ed);
    chk({tag, "_bus9"},   {7'd0, bus9},   eb9);
    chk({tag, "_bus16"},  bus16,          eb16);
    chk({tag, "_done9"},  {15'd0, done9}, {15'd0, ed});
    chk({tag, "_done16"}, {15'd0, done16}, {15'd0, ed});
  endtask

  // Idle in T0 with Run low and junk on DIN; nothing may start.
  task automatic idle(input int n);
    run = 1'b0;
    repeat (n) begin
      din = 16'($urandom);
      @(negedge clk);
      check_step("idle", 16'h0, 16'h0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  // Issue one instruction starting in T0 and check every step.
  // The call starts and ends 1 time unit after a rising edge.
  task automatic issue(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                       input logic [15:0] imm, input logic run_mid, input logic abort);
    logic [15:0] eb [2];
    logic [15:0] eg [2];
    logic        alu;
    alu = (op == 3'b010) || (op == 3'b011) || (op == 3'b100);
    din = {7'($urandom), op, x, y};
    run = 1'b1;
    @(negedge clk);
    check_step("t0", 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    din = imm;
    run = run_mid;
    for (int k = 0; k < 2; k++) begin
      case (op)
        3'b000:  eb[k] = m_r[k][y];
        3'b001:  eb[k] = imm & m_mask[k];
        3'b101:  eb[k] = m_z[k] ? 16'h0000 : m_r[k][y];
        3'b010, 3'b011, 3'b100: eb[k] = m_r[k][x];
        default: eb[k] = 16'h0000;
      endcase
    end
    @(negedge clk);
    check_step("t1", eb[0], eb[1], !alu);
    if (alu) begin
      for (int k = 0; k < 2; k++) eg[k] = ref_alu(op, m_r[k][x], m_r[k][y], m_mask[k]);
      @(posedge clk); #1;
      run = run_mid;
      if (abort) begin
        resetn = 1'b0;
        run = 1'b0;
        #1;
        check_step("rst_t2", 16'h0, 16'h0, 1'b0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      check_step("t2", m_r[0][y], m_r[1][y], 1'b0);
      for (int k = 0; k < 2; k++) m_z[k] = (eg[k] == 16'h0000);
      @(posedge clk); #1;
      run = run_mid;
      @(negedge clk);
      check_step("t3", eg[0], eg[1], 1'b1);
      for (int k = 0; k < 2; k++) m_r[k][x] = eg[k];
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (op == 3'b000 || op == 3'b001 || (op == 3'b101 && !m_z[k])) m_r[k][x] = eb[k];
      end
    end
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    m_mask[0] = 16'h01FF;
    m_mask[1] = 16'hFFFF;
    resetn = 1'b0;
    run    = 1'b0;
    din    = 16'h0000;
    model_reset();
    #3;
    check_step("reset", 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(1);

    // Arithmetic wrap: 0x1FF + 1 wraps to 0 at W=9
    issue(3'b001, 3'd0, 3'd0, 16'h01FF, 1'b0, 1'b0);
    issue(3'b001, 3'd1, 3'd0, 16'h0001, 1'b0, 1'b0);
    issue(3'b010, 3'd0, 3'd1, 16'h0000, 1'b0, 1'b0);
    issue(3'b011, 3'd1, 3'd0, 16'h0000, 1'b0, 1'b0);
    issue(3'b000, 3'd7, 3'd0, 16'h0000, 1'b0, 1'b0);
    issue(3'b000, 3'd7, 3'd1, 16'h0000, 1'b0, 1'b0);

    // mvi/mv with full-width immediate
    issue(3'b001, 3'd3, 3'd0, 16'hBEEF, 1'b0, 1'b0);
    issue(3'b000, 3'd5, 3'd3, 16'h0000, 1'b1, 1'b0);

    // and / mvnz
    issue(3'b001, 3'd6, 3'd0, 16'h0055, 1'b0, 1'b0);
    issue(3'b001, 3'd2, 3'd0, 16'h00F0, 1'b0, 1'b0);
    issue(3'b001, 3'd4, 3'd0, 16'h000F, 1'b0, 1'b0);
    issue(3'b100, 3'd2, 3'd4, 16'h0000, 1'b0, 1'b0);
    issue(3'b101, 3'd6, 3'd4, 16'h0000, 1'b0, 1'b0);
    issue(3'b000, 3'd7, 3'd6, 16'h0000, 1'b0, 1'b0);
    issue(3'b010, 3'd4, 3'd4, 16'h0000, 1'b0, 1'b0);
    issue(3'b101, 3'd6, 3'd4, 16'h0000, 1'b0, 1'b0);
    issue(3'b000, 3'd7, 3'd6, 16'h0000, 1'b0, 1'b0);

    // Run gating, nop, Run pulse during an ALU op
    idle(5);
    issue(3'b111, 3'd1, 3'd2, 16'h1234, 1'b0, 1'b0);
    issue(3'b110, 3'd3, 3'd3, 16'h4321, 1'b1, 1'b0);
    issue(3'b000, 3'd0, 3'd6, 16'h0000, 1'b0, 1'b0);
    issue(3'b010, 3'd2, 3'd6, 16'h0000, 1'b1, 1'b0);
    issue(3'b000, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b0);

    // Reset in T2 of an add, then mv R1,R0 must read 0
    issue(3'b001, 3'd0, 3'd0, 16'h0123, 1'b0, 1'b0);
    issue(3'b010, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1);
    issue(3'b000, 3'd1, 3'd0, 16'h0000, 1'b0, 1'b0);

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_w.md
# proc_w

Parametrised successor of the team's 9-bit multicycle bus processor. It executes the same instruction encoding (mv, mvi, add, sub) over a data path of configurable width W. It adds three behaviours: a logical AND, a conditional move on a zero flag, and an explicit no-op. All architectural state is asynchronously reset. It sits between the instruction/data source driving DIN and any logic observing BusWires/Done.

## Interface
- W, default 9, data/bus/register width in bits; legal range W >= 9.
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous, active-low reset.
- DIN  input  W  instruction word (fetch) or immediate operand (mvi).
- Run  input  1  start request; sampled only in T0.
- Done  output  1  high for exactly the final step of each instruction.
- BusWires  output  W  current value of the internal shared bus.

## Operation
- Instruction fields, latched in IR from DIN[8:0]:
  - opcode = IR[8:6]
  - X = IR[5:3], the destination register and first operand.
  - Y = IR[2:0], the second operand.
  - DIN[W-1:9] are ignored at fetch.
- Architectural state:
  - Registers R0..R7, each W bits.
  - Accumulator A (W), result register G (W), IR (9).
  - Flag Z, equal to 1 when the last value written to G was zero.
- Bus sources: Rout[Y or X], G, DIN. At most one source is enabled per cycle. When none is enabled, BusWires = 0.
- Step counter states: T0, T1, T2, T3.
  - T0, fetch: IR <= DIN[8:0] when Run=1, then go to T1. With Run=0, stay in T0 and IR holds.
  - T1:
    - mv (000): bus=R[Y], R[X]<=bus, Done=1, then T0.
    - mvi (001): bus=DIN (full W bits), R[X]<=bus, Done=1, then T0.
    - mvnz (101): if Z=0, bus=R[Y] and R[X]<=bus; if Z=1, no source and no write. Done=1 in both cases, then T0.
    - nop (110, 111): no source, no write, Done=1, then T0.
    - add/sub/and (010/011/100): bus=R[X], A<=bus, then T2.
  - T2, ALU ops only: bus=R[Y], G<=f(A,bus), Z<=(f(A,bus)==0), then T3.
  - T3, ALU ops only: bus=G, R[X]<=bus, Done=1, then T0.
- ALU functions:
  - add: A+bus mod 2^W.
  - sub: A-bus mod 2^W, two's complement.
  - and: bitwise A&bus.
  - No carry or overflow is kept.
- Same-register forms (X=Y) are legal and use the values present at each step. For example, add R2,R2 doubles R2.
- Run is ignored in T1..T3; a new instruction begins only from T0.
- Done is a Moore output decoded from the step and IR. It is never asserted in T0.

## Timing
- Reset (Resetn=0, asynchronous) forces:
  - step=T0, Done=0, BusWires=0.
  - R0..R7=0, A=0, G=0, IR=0, Z=1.
- Reset mid-instruction aborts the instruction with no further register writes. The step returns to T0 immediately, not on the next clock.
- Latency from the Run-sampling edge in T0 to the edge that retires the instruction:
  - mv/mvi/mvnz/nop: 1 cycle (T1).
  - add/sub/and: 3 cycles (T1, T2, T3).
- Register writes take effect on the clock edge ending the step in which Done=1. The new value is visible on the bus from the next cycle.
- Back-to-back issue: holding Run=1 fetches the next instruction in the T0 that follows Done. Minimum instruction periods:
  - 2 cycles for mv/mvi/mvnz/nop.
  - 4 cycles for ALU ops.
- Z changes only on the T2 edge of an ALU op. mv, mvi and mvnz leave Z unchanged.
- BusWires is combinational from the step, IR, Z and register state. It is valid within the cycle.

## Test plan
- Reset with W=9: assert Resetn=0 mid-add (in T2).
  - Required: Done=0 and BusWires=0 at once.
  - Required: after release, mv R1,R0 yields BusWires=0 in T1.
- mvi/mv with W=16:
  - mvi R3 with DIN=0xBEEF yields R3=0xBEEF.
  - mv R5,R3 then shows BusWires=0xBEEF in T1 with Done=1.
  - Each instruction takes 2 cycles.
- Arithmetic wrap with W=9:
  - R0=0x1FF, R1=0x001, add R0,R1 gives R0=0x000 and Z=1.
  - sub R1,R0 gives R1=0x001.
  - Done is high only in T3.
- and/mvnz with W=9:
  - R2=0x0F0, R4=0x00F, and R2,R4 gives R2=0 and Z=1. mvnz R6,R4 then leaves R6 unchanged.
  - Next, add R4,R4 gives 0x01E and Z=0. mvnz R6,R4 then gives R6=0x01E.
- Run gating and nop:
  - Run=0 for 5 cycles: step stays in T0, IR holds, Done=0.
  - Opcode 111: Done=1 in T1, no register changes, BusWires=0.
  - Pulsing Run during T2 of an add has no effect on that add.
